// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: ciphertext+key in, plaintext out, one inverse round per cycle.
// Latency: 20 cycles from acceptance to out_valid (10 when the key-cache hits, AES_DEC_KEYCACHE_EN).
// Backpressure: in_ready only in IDLE; DONE holds out_valid/out_data until out_ready.
module aes128_decrypt_iter (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   typedef enum logic [2:0] {IDLE, KEYEXP, ROUND, FINAL, DONE} st_t;

   // Byte i of a block lives at [127-8i -: 8]; table entry i is the image of byte value i.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] n);
      case (n)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Row r rotates right by r: output (r,c) comes from input (r,c-r).
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++)
            o[127-8*(rr+4*c) -: 8] = INV_SBOX[s[127-8*(rr+4*((c-rr+4)%4)) -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) begin
            a[i]  = s[127-8*(i+4*c) -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
         end
         // coefficient rows 0e 0b 0d 09, rotated per output byte
         for (int i = 0; i < 4; i++)
            o[127-8*(i+4*c) -: 8] =
                 (x8[i]       ^ x4[i]       ^ x2[i])              // 0e
               ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])         // 0b
               ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])         // 0d
               ^ (x8[(i+3)%4] ^ a[(i+3)%4]);                      // 09
      end
      return o;
   endfunction

   st_t          st;
   logic [127:0] state_q;
   logic [127:0] rk [0:10];
   logic [3:0]   kc;
   logic [3:0]   r;
   logic         hit;

   logic [127:0] rk_prev, rk_next, rk_r;
   logic [31:0]  temp, n0, n1, n2, n3;
   logic [127:0] inv_ss, round_out, final_out;

`ifdef AES_DEC_KEYCACHE_EN
   logic cache_vld;
   assign hit = cache_vld && (key == rk[0]);
`else
   assign hit = 1'b0;
`endif

   // One forward key-schedule step: rk[kc] from rk[kc-1]
   always_comb begin
      rk_prev = rk[0];
      if (kc != 4'd0 && kc <= 4'd11)
         rk_prev = rk[kc - 4'd1];
      temp = {SBOX[rk_prev[23:16]], SBOX[rk_prev[15:8]], SBOX[rk_prev[7:0]], SBOX[rk_prev[31:24]]}
             ^ {rcon(kc), 24'h0};
      n0 = rk_prev[127:96] ^ temp;
      n1 = rk_prev[95:64]  ^ n0;
      n2 = rk_prev[63:32]  ^ n1;
      n3 = rk_prev[31:0]   ^ n2;
      rk_next = {n0, n1, n2, n3};
   end

   // Shared inverse-round datapath for ROUND and FINAL
   always_comb begin
      rk_r      = rk[0];
      if (r <= 4'd10)
         rk_r = rk[r];
      inv_ss    = inv_shift_sub(state_q);
      round_out = inv_mix(inv_ss ^ rk_r);
      final_out = inv_ss ^ rk[0];
   end

   // Control FSM, key store and state register; all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         state_q   <= '0;
         kc        <= '0;
         r         <= '0;
         for (int i = 0; i <= 10; i++)
            rk[i] <= '0;
`ifdef AES_DEC_KEYCACHE_EN
         cache_vld <= 1'b0;
`endif
      end else begin
         case (st)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  rk[0]    <= key;
                  if (hit) begin
                     state_q <= in_data ^ rk[10];
                     r       <= 4'd9;
                     st      <= ROUND;
                  end else begin
                     state_q <= in_data;
                     kc      <= 4'd1;
                     st      <= KEYEXP;
`ifdef AES_DEC_KEYCACHE_EN
                     cache_vld <= 1'b0;
`endif
                  end
               end
            end
            KEYEXP: begin
               rk[kc] <= rk_next;
               kc     <= kc + 4'd1;
               if (kc == 4'd10) begin
                  state_q <= state_q ^ rk_next;
                  r       <= 4'd9;
                  st      <= ROUND;
`ifdef AES_DEC_KEYCACHE_EN
                  cache_vld <= 1'b1;
`endif
               end
            end
            ROUND: begin
               state_q <= round_out;
               r       <= r - 4'd1;
               if (r == 4'd1)
                  st <= FINAL;
            end
            FINAL: begin
               out_data  <= final_out;
               out_valid <= 1'b1;
               st        <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  st        <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter: randomized encrypt->decrypt round trips against a byte-level AES model.
// Latency: expected output timeline derived from the acceptance/latency rules, checked every cycle.
// Backpressure: out_ready held low for random/long stretches; in_valid held until in_ready.
module tb_aes128_decrypt_iter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic [127:0] key = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] out_data;

`ifdef AES_DEC_KEYCACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   always #5 clk = ~clk;

   aes128_decrypt_iter dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .key(key), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- byte-level AES encryption model ----------------
   logic [7:0] sb [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [127:0] o;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
         for (int c = 0; c < 4; c++) begin
            if (rnd < 10) begin
               s[4*c]   = gmul(t[4*c],8'h02) ^ gmul(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],8'h02) ^ gmul(t[4*c+2],8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],8'h02) ^ gmul(t[4*c+3],8'h03);
               s[4*c+3] = gmul(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],8'h02);
            end else begin
               for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*c+rr];
            end
            for (int rr = 0; rr < 4; rr++) s[4*c+rr] ^= w[4*rnd+c][31-8*rr -: 8];
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   // ---------------- cycle-level expectation of the handshake timeline ----------------
   logic [127:0] cur_pt = '0;
   logic         e_rdy = 1'b1, e_vld = 1'b0, busy = 1'b0, cache_v = 1'b0;
   logic [127:0] e_dat = '0, pend = '0, cache_key = '0;
   int           rem = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         e_rdy = 1'b1; e_vld = 1'b0; e_dat = '0; busy = 1'b0; cache_v = 1'b0; rem = 0;
      end else begin
         chk("mon_in_ready",  128'(in_ready),  128'(e_rdy));
         chk("mon_out_valid", 128'(out_valid), 128'(e_vld));
         chk("mon_out_data",  out_data, e_dat);
         if (e_rdy && in_valid) begin
            rem       = (CACHE && cache_v && key == cache_key) ? 10 : 20;
            busy      = 1'b1;
            e_rdy     = 1'b0;
            pend      = cur_pt;
            cache_key = key;
            cache_v   = 1'b1;
         end else if (busy) begin
            rem--;
            if (rem == 0) begin
               busy  = 1'b0;
               e_vld = 1'b1;
               e_dat = pend;
            end
         end else if (e_vld && out_ready) begin
            e_vld = 1'b0;
            e_rdy = 1'b1;
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
      int n;
      @(posedge clk); #1;
      cur_pt = pt; in_data = ct; key = k; in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 100) begin
            chk("accept_timeout", 128'(in_ready), 128'(1));
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      key      = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic recv(input int hold, output int lat, output logic [127:0] res);
      lat = 0;
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         lat++;
         in_data = {$urandom, $urandom, $urandom, $urandom};
         if (out_valid) break;
         if (lat > 60) begin
            chk("done_timeout", 128'(out_valid), 128'(1));
            break;
         end
      end
      res = out_data;
      repeat (hold) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("in_ready_after_handshake", 128'(in_ready), 128'(1));
   endtask

   initial begin
      int           lat;
      logic [127:0] res, k, last_key, pt;
      build_sbox();
      chk("model_c1_enc", aes_enc(C1_PT, C1_KEY), C1_CT);
      chk("model_appb_enc", aes_enc(B_PT, B_KEY), B_CT);

      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready",  128'(in_ready),  128'(1));
      chk("reset_out_valid", 128'(out_valid), 128'(0));
      chk("reset_out_data",  out_data, 128'h0);
      rst_n = 1'b1;

      send(C1_KEY, C1_CT, C1_PT);  recv(0, lat, res);
      chk("c1_latency", 128'(lat), 128'(20));
      chk("c1_plaintext", res, C1_PT);

      send(C1_KEY, C1_CT, C1_PT);  recv(0, lat, res);
      chk("c1_repeat_latency", 128'(lat), 128'(CACHE ? 10 : 20));
      chk("c1_repeat_plaintext", res, C1_PT);

      send(B_KEY, B_CT, B_PT);     recv(15, lat, res);
      chk("appb_latency", 128'(lat), 128'(20));
      chk("appb_plaintext", res, B_PT);

      // abort at ROUND r=5 with an asynchronous reset
      send(C1_KEY, C1_CT, C1_PT);  recv(0, lat, res);
      send(C1_KEY, C1_CT, C1_PT);
      repeat (CACHE ? 4 : 14) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_in_ready",  128'(in_ready),  128'(1));
      chk("abort_out_valid", 128'(out_valid), 128'(0));
      chk("abort_out_data",  out_data, 128'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(C1_KEY, C1_CT, C1_PT);  recv(0, lat, res);
      chk("post_reset_latency", 128'(lat), 128'(20));
      chk("post_reset_plaintext", res, C1_PT);

      last_key = C1_KEY;
      for (int v = 0; v < 1000; v++) begin
         k  = ($urandom_range(0, 3) == 0) ? last_key : {$urandom, $urandom, $urandom, $urandom};
         pt = {$urandom, $urandom, $urandom, $urandom};
         send(k, aes_enc(pt, k), pt);
         recv($urandom_range(0, 2), lat, res);
         chk("rt_latency", 128'(lat), 128'((CACHE && k == last_key) ? 10 : 20));
         chk("rt_plaintext", res, pt);
         last_key = k;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
